// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset PC, bubble encoding and fetch FSM states.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_BUF  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_pc_register.sv
// Program counter with priority load over sequential increment; 32-bit wrap on increment.
module if_fetch_unit_pc_register
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = RESET_PC,
    parameter logic [31:0] STEP        = PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] load_addr,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_VALUE;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + STEP;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, talks to a variable-latency imem, applies redirects and freeze.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P  = RESET_PC,
    parameter logic [31:0] PC_STEP_P   = PC_STEP,
    parameter logic [31:0] NOP_INSTR_P = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_rd_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        fetch_valid
);

    fetch_state_t state, next_state;
    logic [31:0]  pc_reg;
    logic [31:0]  buf_word;
    logic         redirect_pend;
    logic [31:0]  redirect_addr;

    logic         pc_load, pc_inc, buf_load, pend_set, pend_clr;
    logic [31:0]  load_addr;
    logic         rd_req_c, valid_c;
    logic [31:0]  instr_c;

    if_fetch_unit_pc_register #(
        .RESET_VALUE (RESET_PC_P),
        .STEP        (PC_STEP_P)
    ) pc_register (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .inc       (pc_inc),
        .load_addr (load_addr),
        .pc        (pc_reg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_REQ;
            buf_word      <= '0;
            redirect_pend <= 1'b0;
            redirect_addr <= '0;
        end else begin
            state <= next_state;
            if (buf_load) begin
                buf_word <= imem_rdata;
            end
            if (pend_set) begin
                redirect_pend <= 1'b1;
                redirect_addr <= branch_addr;
            end else if (pend_clr) begin
                redirect_pend <= 1'b0;
            end
        end
    end

    // REQ and WAIT share one arm: redirect_pend can only be set while a request is outstanding.
    always_comb begin
        next_state = state;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        load_addr  = branch_addr;
        buf_load   = 1'b0;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        rd_req_c   = 1'b0;
        valid_c    = 1'b0;
        instr_c    = NOP_INSTR_P;
        case (state)
            S_REQ, S_WAIT: begin
                rd_req_c = 1'b1;
                if (!imem_ready) begin
                    // The transaction cannot be abandoned, so a redirect is parked until it completes.
                    next_state = S_WAIT;
                    pend_set   = branch_taken;
                end else if (branch_taken) begin
                    pc_load    = 1'b1;
                    pend_clr   = 1'b1;
                    next_state = S_REQ;
                end else if (redirect_pend) begin
                    pc_load    = 1'b1;
                    load_addr  = redirect_addr;
                    pend_clr   = 1'b1;
                    next_state = S_REQ;
                end else begin
                    instr_c = imem_rdata;
                    valid_c = 1'b1;
                    if (freeze) begin
                        buf_load   = 1'b1;
                        next_state = S_BUF;
                    end else begin
                        pc_inc     = 1'b1;
                        next_state = S_REQ;
                    end
                end
            end
            S_BUF: begin
                if (branch_taken) begin
                    pc_load    = 1'b1;
                    next_state = S_REQ;
                end else begin
                    instr_c = buf_word;
                    valid_c = 1'b1;
                    if (!freeze) begin
                        pc_inc     = 1'b1;
                        next_state = S_REQ;
                    end
                end
            end
            default: next_state = S_REQ;
        endcase
    end

    // Reset gates the request and the fetched word immediately, independent of the clock.
    assign imem_rd_req = rd_req_c & ~rst;
    assign fetch_valid = valid_c & ~rst;
    assign Instruction = rst ? NOP_INSTR_P : instr_c;
    assign imem_addr   = pc_reg;
    assign PC          = pc_reg + PC_STEP_P;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an expected-fetch queue drained by a monitor.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_ready = 1'b1;
    logic        imem_rd_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        fetch_valid;

    int checks = 0;
    int errors = 0;
    int rd_cnt_10 = 0;
    logic [63:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'hE3A0_1005 : {16'hC0DE, a[15:0]};
    endfunction

    // memory model: data only meaningful with ready, garbage otherwise
    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_rd_req  (imem_rd_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .PC           (pc_out),
        .Instruction  (instruction),
        .fetch_valid  (fetch_valid)
    );

    // driver tasks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] w);
        exp_q.push_back({p, w});
    endtask

    task automatic cyc(input logic rdy, input logic frz, input logic br, input logic [31:0] ba);
        imem_ready   = rdy;
        freeze       = frz;
        branch_taken = br;
        branch_addr  = ba;
        @(negedge clk);
    endtask

    task automatic step(input logic rdy, input logic frz, input logic br, input logic [31:0] ba);
        @(posedge clk);
        #1;
        cyc(rdy, frz, br, ba);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        imem_ready = 1'b0;
        freeze = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && imem_rd_req && imem_ready && imem_addr == 32'h10) rd_cnt_10++;
        if (!rst && fetch_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fetch: got pc=%h instr=%h expected no fetch", pc_out, instruction);
            end else begin
                e = exp_q.pop_front();
                if ({pc_out, instruction} !== e) begin
                    errors++;
                    $display("FAIL fetch: got pc=%h instr=%h expected pc=%h instr=%h",
                             pc_out, instruction, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        // reset outputs (memory ready during reset must not leak through)
        @(negedge clk);
        chk("rst_rd_req", {31'b0, imem_rd_req}, 32'd0);
        chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc", pc_out, 32'h4);
        chk("rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // zero-wait sequential fetch
        push(32'h4, 32'hC0DE_0000); cyc(1, 0, 0, 0);  chk("a0_addr", imem_addr, 32'h0);
        push(32'h8, 32'hC0DE_0004); step(1, 0, 0, 0); chk("a1_addr", imem_addr, 32'h4);
        push(32'hC, 32'hC0DE_0008); step(1, 0, 0, 0); chk("a2_addr", imem_addr, 32'h8);
        push(32'h10, 32'hC0DE_000C); step(1, 0, 0, 0); chk("a3_addr", imem_addr, 32'hC);

        // two wait cycles at 0x8
        do_reset();
        push(32'h4, 32'hC0DE_0000); cyc(1, 0, 0, 0);
        push(32'h8, 32'hC0DE_0004); step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("b2_valid", {31'b0, fetch_valid}, 32'd0);
        chk("b2_instr", instruction, 32'h0);
        chk("b2_addr", imem_addr, 32'h8);
        chk("b2_req", {31'b0, imem_rd_req}, 32'd1);
        step(0, 0, 0, 0);
        chk("b3_valid", {31'b0, fetch_valid}, 32'd0);
        chk("b3_addr", imem_addr, 32'h8);
        push(32'hC, 32'hC0DE_0008); step(1, 0, 0, 0); chk("b4_addr", imem_addr, 32'h8);
        push(32'h10, 32'hC0DE_000C); step(1, 0, 0, 0);

        // freeze for 3 cycles on the word at 0x10
        push(32'h14, 32'hE3A0_1005); step(1, 1, 0, 0); chk("c0_addr", imem_addr, 32'h10);
        push(32'h14, 32'hE3A0_1005); step(1, 1, 0, 0); chk("c1_req", {31'b0, imem_rd_req}, 32'd0);
        push(32'h14, 32'hE3A0_1005); step(1, 1, 0, 0); chk("c2_req", {31'b0, imem_rd_req}, 32'd0);
        push(32'h14, 32'hE3A0_1005); step(1, 0, 0, 0); chk("c3_req", {31'b0, imem_rd_req}, 32'd0);
        push(32'h18, 32'hC0DE_0014); step(1, 0, 0, 0); chk("c4_addr", imem_addr, 32'h14);
        chk("c_reads_0x10", rd_cnt_10, 32'd1);

        // branch while a request is outstanding
        step(0, 0, 0, 0);               chk("d0_addr", imem_addr, 32'h18);
        step(0, 0, 1, 32'h100);         chk("d1_valid", {31'b0, fetch_valid}, 32'd0);
        step(0, 0, 0, 0);               chk("d2_addr", imem_addr, 32'h18);
        step(1, 0, 0, 0);
        chk("d3_valid", {31'b0, fetch_valid}, 32'd0);
        chk("d3_instr", instruction, 32'h0);
        push(32'h104, 32'hC0DE_0100); step(1, 0, 0, 0); chk("d4_addr", imem_addr, 32'h100);

        // branch with freeze while buffering
        push(32'h108, 32'hC0DE_0104); step(1, 1, 0, 0);
        step(1, 1, 1, 32'h200);
        chk("e1_valid", {31'b0, fetch_valid}, 32'd0);
        chk("e1_instr", instruction, 32'h0);
        chk("e1_req", {31'b0, imem_rd_req}, 32'd0);
        push(32'h204, 32'hC0DE_0200); step(1, 0, 0, 0); chk("e2_addr", imem_addr, 32'h200);

        // branch in REQ with ready low: transaction still completes at the old address
        step(0, 0, 1, 32'h300);         chk("e3_valid", {31'b0, fetch_valid}, 32'd0);
        step(1, 0, 0, 0);               chk("e4_addr", imem_addr, 32'h204);
        chk("e4_valid", {31'b0, fetch_valid}, 32'd0);
        push(32'h304, 32'hC0DE_0300); step(1, 0, 0, 0); chk("e5_addr", imem_addr, 32'h300);

        // latest of two pending redirects wins
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h400);
        step(0, 0, 1, 32'h500);
        step(1, 0, 0, 0);               chk("e9_valid", {31'b0, fetch_valid}, 32'd0);
        push(32'h504, 32'hC0DE_0500); step(1, 0, 0, 0); chk("e10_addr", imem_addr, 32'h500);

        // branch coinciding with the completing ready
        step(0, 0, 0, 0);
        step(1, 0, 1, 32'h600);         chk("e12_valid", {31'b0, fetch_valid}, 32'd0);
        push(32'h604, 32'hC0DE_0600); step(1, 0, 0, 0); chk("e13_addr", imem_addr, 32'h600);

        // asynchronous reset mid-WAIT with a pending redirect
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h700);
        #2;
        rst = 1'b1;
        #1;
        chk("f_rst_req", {31'b0, imem_rd_req}, 32'd0);
        chk("f_rst_valid", {31'b0, fetch_valid}, 32'd0);
        chk("f_rst_addr", imem_addr, 32'h0);
        chk("f_rst_pc", pc_out, 32'h4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        chk("f0_addr", imem_addr, 32'h0);
        chk("f0_req", {31'b0, imem_rd_req}, 32'd1);
        push(32'h4, 32'hC0DE_0000); step(1, 0, 0, 0);
        push(32'h8, 32'hC0DE_0004); step(1, 0, 0, 0); chk("f2_addr", imem_addr, 32'h4);

        // PC wrap at the top of the address space
        step(1, 0, 1, 32'hFFFF_FFFC);   chk("g0_valid", {31'b0, fetch_valid}, 32'd0);
        push(32'h0, 32'hC0DE_FFFC); step(1, 0, 0, 0);
        chk("g1_addr", imem_addr, 32'hFFFF_FFFC);
        chk("g1_pc", pc_out, 32'h0);
        push(32'h4, 32'hC0DE_0000); step(1, 0, 0, 0); chk("g2_addr", imem_addr, 32'h0);

        step(0, 0, 0, 0);
        chk("queue_drained", exp_q.size(), 32'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
